// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: latency-class encoding (same as the decoder's)
// and the stall-cause vector layout.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2
    } lat_cls_e;

    typedef struct packed {
        logic waw;
        logic br_raw;
        logic ex_raw;
    } stall_src_t;

    // Unknown classes fall back to the slowest producer so a bad decode can only over-stall.
    function automatic int unsigned lat_sel(input logic [1:0] cls,
                                            input int unsigned alu_lat,
                                            input int unsigned load_lat,
                                            input int unsigned mul_lat);
        int unsigned lat;
        case (cls)
            LAT_ALU:  lat = alu_lat;
            LAT_LOAD: lat = load_lat;
            default:  lat = mul_lat;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage side of the hazard scoreboard: decoded operand info in, stall/issue decision out.
interface hazard_scoreboard_if #(
    parameter int AW  = 5,
    parameter int SCW = 32
);
    logic           id_valid;
    logic [AW-1:0]  id_rs1;
    logic [AW-1:0]  id_rs2;
    logic           id_rs1_used;
    logic           id_rs2_used;
    logic           id_br_use;
    logic [AW-1:0]  id_rd;
    logic           id_regwrite;
    logic [1:0]     id_lat_cls;
    logic           flush_id;
    logic           flush_all;
    logic           stall;
    logic [2:0]     stall_src;
    logic           issue;
    logic [SCW-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_br_use,
               id_rd, id_regwrite, id_lat_cls, flush_id, flush_all,
        input  stall, stall_src, issue, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_br_use,
               id_rd, id_regwrite, id_lat_cls, flush_id, flush_all,
        output stall, stall_src, issue, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_pend_cell.sv
// One register's countdown: cycles left until its in-flight result can be forwarded.
module hazard_pend_cell #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count
);

    // Clear beats load so a redirect never leaves a stale producer behind.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register forward countdowns for variable-latency producers,
// RAW/WAW stall decision for the instruction in ID, and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int CW       = 3,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int SCW      = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_scoreboard_if.slave sb
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][CW-1:0] pend;
    logic [CW-1:0]           lat;
    logic [CW-1:0]           pend_rs1;
    logic [CW-1:0]           pend_rs2;
    logic [CW-1:0]           pend_rd;
    logic [AW-1:0]           rs1;
    logic [AW-1:0]           rs2;
    logic [AW-1:0]           rd;
    logic                    id_live;
    logic                    any_cause;
    logic                    stall_int;
    logic                    issue_int;
    logic                    wr_en;
    stall_src_t              cause;
    logic [SCW-1:0]          stall_count_q;

    assign rs1 = sb.id_rs1;
    assign rs2 = sb.id_rs2;
    assign rd  = sb.id_rd;

    assign lat = CW'(lat_sel(sb.id_lat_cls, ALU_LAT, LOAD_LAT, MUL_LAT));

    // x0 is hardwired, so its countdown never exists as state.
    assign pend[0] = '0;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_pend
            hazard_pend_cell #(.CW(CW)) u_cell (
                .clk      (clk),
                .rst      (rst),
                .clear    (sb.flush_all),
                .load     (wr_en && (rd == AW'(r))),
                .load_val (lat),
                .count    (pend[r])
            );
        end
    endgenerate

    // Unused or x0 sources contribute nothing.
    always_comb begin
        pend_rs1 = '0;
        pend_rs2 = '0;
        if (sb.id_rs1_used && (rs1 != '0)) pend_rs1 = pend[rs1];
        if (sb.id_rs2_used && (rs2 != '0)) pend_rs2 = pend[rs2];
        pend_rd = pend[rd];
    end

    // EX can take a forward once the countdown hits 1; ID-resolved branches need it fully done.
    always_comb begin
        cause        = '0;
        cause.ex_raw = (pend_rs1 > CW'(1)) || (pend_rs2 > CW'(1));
        cause.br_raw = sb.id_br_use && ((pend_rs1 != '0) || (pend_rs2 != '0));
        cause.waw    = sb.id_regwrite && (rd != '0) && (pend_rd > lat);
    end

    assign id_live   = sb.id_valid && !sb.flush_id && !sb.flush_all && !rst;
    assign any_cause = cause.ex_raw || cause.br_raw || cause.waw;
    assign stall_int = id_live && any_cause;
    assign issue_int = id_live && !any_cause;
    assign wr_en     = issue_int && sb.id_regwrite && (rd != '0);

    assign sb.stall     = stall_int;
    assign sb.stall_src = stall_int ? cause : 3'b000;
    assign sb.issue     = issue_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (stall_int && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + SCW'(1);
        end
    end

    // Gated so the counter reads zero for the whole reset window, not just after the edge.
    assign sb.stall_count = rst ? '0 : stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: literal checks at key points plus a ready-time model
// compared against the DUT on every cycle.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int SCW     = 4;
    localparam int CNT_MAX = (1 << SCW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(5), .SCW(SCW)) sb_if ();

    hazard_scoreboard #(
        .NREG(32), .CW(3), .ALU_LAT(1), .LOAD_LAT(2), .MUL_LAT(4), .SCW(SCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: absolute cycle at which each register's result becomes fully available.
    int ready_at [32];
    int cyc       = 0;
    int exp_count = 0;

    function automatic int lat_of(input logic [1:0] cls);
        if (cls == 2'd0) return 1;
        if (cls == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int remaining(input logic [4:0] r);
        if (r == 5'd0) return 0;
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model compare, then advance the model across the coming edge.
    always @(negedge clk) begin
        int  p1, p2, lat;
        logic live, e_ex, e_br, e_waw, e_stall, e_issue;
        p1    = sb_if.id_rs1_used ? remaining(sb_if.id_rs1) : 0;
        p2    = sb_if.id_rs2_used ? remaining(sb_if.id_rs2) : 0;
        lat   = lat_of(sb_if.id_lat_cls);
        e_ex  = (p1 > 1) || (p2 > 1);
        e_br  = sb_if.id_br_use && ((p1 != 0) || (p2 != 0));
        e_waw = sb_if.id_regwrite && (sb_if.id_rd != 5'd0) && (remaining(sb_if.id_rd) > lat);
        live  = sb_if.id_valid && !sb_if.flush_id && !sb_if.flush_all && !rst;
        e_stall = live && (e_ex || e_br || e_waw);
        e_issue = live && !e_stall;
        check_val("model_stall", 32'(sb_if.stall), 32'(e_stall));
        check_val("model_src", 32'(sb_if.stall_src), e_stall ? 32'({e_waw, e_br, e_ex}) : 32'd0);
        check_val("model_issue", 32'(sb_if.issue), 32'(e_issue));
        check_val("model_count", 32'(sb_if.stall_count), rst ? 32'd0 : 32'(exp_count));
        if (rst || sb_if.flush_all) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
        end else if (e_issue && sb_if.id_regwrite && (sb_if.id_rd != 5'd0)) begin
            ready_at[sb_if.id_rd] = cyc + 1 + lat;
        end
        if (rst) exp_count = 0;
        else if (e_stall && (exp_count < CNT_MAX)) exp_count++;
        cyc++;
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic br,
                                 input logic [4:0] rd, input logic wr, input logic [1:0] cls,
                                 input logic fid, input logic fall);
        sb_if.id_valid    = v;
        sb_if.id_rs1      = rs1;
        sb_if.id_rs1_used = u1;
        sb_if.id_rs2      = rs2;
        sb_if.id_rs2_used = u2;
        sb_if.id_br_use   = br;
        sb_if.id_rd       = rd;
        sb_if.id_regwrite = wr;
        sb_if.id_lat_cls  = cls;
        sb_if.flush_id    = fid;
        sb_if.flush_all   = fall;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_stall, input logic [2:0] e_src,
                               input logic e_issue);
        check_val({name, "_stall"}, 32'(sb_if.stall), 32'(e_stall));
        check_val({name, "_src"}, 32'(sb_if.stall_src), 32'(e_src));
        check_val({name, "_issue"}, 32'(sb_if.issue), 32'(e_issue));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, LAT_ALU, 1'b0, 1'b0);
    endtask

    task automatic op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic wr, input logic br, input logic [1:0] cls);
        applyStimulus(1'b1, rs1, 1'b1, rs2, 1'b1, br, rd, wr, cls, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        checkOutput("reset", 1'b0, 3'b000, 1'b0);
        check_val("reset_count", 32'(sb_if.stall_count), 32'd0);
        rst = 1'b0;

        // Load-use: one bubble for an EX consumer.
        op(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LAT_LOAD);
        checkOutput("t1_load", 1'b0, 3'b000, 1'b1);
        tick();
        op(5'd6, 5'd5, 5'd1, 1'b1, 1'b0, LAT_ALU);
        checkOutput("t1_use_stall", 1'b1, 3'b001, 1'b0);
        tick();
        checkOutput("t1_use_issue", 1'b0, 3'b000, 1'b1);
        tick();

        // Load then branch: two bubbles.
        do_reset();
        op(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LAT_LOAD);
        checkOutput("t2_load", 1'b0, 3'b000, 1'b1);
        tick();
        op(5'd0, 5'd5, 5'd0, 1'b0, 1'b1, LAT_ALU);
        checkOutput("t2_br_c1", 1'b1, 3'b011, 1'b0);
        tick();
        checkOutput("t2_br_c2", 1'b1, 3'b010, 1'b0);
        tick();
        checkOutput("t2_br_issue", 1'b0, 3'b000, 1'b1);
        check_val("t2_count", 32'(sb_if.stall_count), 32'd2);
        tick();

        // WAW behind a multiply, then a RAW consumer that forwards without stalling.
        do_reset();
        op(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, LAT_MUL);
        checkOutput("t3_mul", 1'b0, 3'b000, 1'b1);
        tick();
        op(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, LAT_ALU);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_waw", 1'b1, 3'b100, 1'b0);
            tick();
        end
        checkOutput("t3_add_issue", 1'b0, 3'b000, 1'b1);
        tick();
        op(5'd8, 5'd7, 5'd7, 1'b1, 1'b0, LAT_ALU);
        checkOutput("t3_sub_issue", 1'b0, 3'b000, 1'b1);
        tick();

        // x0 is never busy, even with other registers pending.
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            op(5'(r), 5'd0, 5'd0, 1'b1, 1'b0, LAT_MUL);
            tick();
        end
        op(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, LAT_MUL);
        checkOutput("t4_x0_a", 1'b0, 3'b000, 1'b1);
        tick();
        checkOutput("t4_x0_b", 1'b0, 3'b000, 1'b1);
        tick();

        // flush_all clears pending producers and blocks a same-cycle load.
        do_reset();
        op(5'd9, 5'd1, 5'd2, 1'b1, 1'b0, LAT_MUL);
        checkOutput("t5_mul", 1'b0, 3'b000, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 1'b1, LAT_ALU, 1'b0, 1'b1);
        checkOutput("t5_flush", 1'b0, 3'b000, 1'b0);
        tick();
        op(5'd1, 5'd9, 5'd9, 1'b1, 1'b1, LAT_ALU);
        checkOutput("t5_after_flush", 1'b0, 3'b000, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, LAT_MUL, 1'b0, 1'b1);
        checkOutput("t5_issue_flush", 1'b0, 3'b000, 1'b0);
        tick();
        op(5'd0, 5'd9, 5'd9, 1'b0, 1'b1, LAT_ALU);
        checkOutput("t5_no_load", 1'b0, 3'b000, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, LAT_MUL, 1'b1, 1'b0);
        checkOutput("t5_flush_id", 1'b0, 3'b000, 1'b0);
        tick();
        op(5'd0, 5'd10, 5'd0, 1'b0, 1'b1, LAT_ALU);
        checkOutput("t5_after_flush_id", 1'b0, 3'b000, 1'b1);
        tick();

        // Illegal latency class behaves like a multiply.
        op(5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 2'd3);
        checkOutput("ill_issue", 1'b0, 3'b000, 1'b1);
        tick();
        op(5'd0, 5'd11, 5'd0, 1'b0, 1'b1, LAT_ALU);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ill_br", 1'b1, (i < 3) ? 3'b011 : 3'b010, 1'b0);
            tick();
        end
        checkOutput("ill_br_issue", 1'b0, 3'b000, 1'b1);
        tick();

        // Reset in the middle of a load-use stall.
        do_reset();
        op(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, LAT_LOAD);
        tick();
        op(5'd6, 5'd5, 5'd1, 1'b1, 1'b0, LAT_ALU);
        checkOutput("t6_pre_rst", 1'b1, 3'b001, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_drop", 1'b0, 3'b000, 1'b0);
        check_val("t6_rst_count", 32'(sb_if.stall_count), 32'd0);
        tick();
        rst = 1'b0;
        op(5'd0, 5'd5, 5'd0, 1'b0, 1'b1, LAT_ALU);
        checkOutput("t6_pend_clear", 1'b0, 3'b000, 1'b1);
        tick();

        // Saturation: four stalls per round, five rounds.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            op(5'd2, 5'd0, 5'd0, 1'b1, 1'b0, LAT_MUL);
            checkOutput("sat_mul", 1'b0, 3'b000, 1'b1);
            tick();
            op(5'd0, 5'd2, 5'd0, 1'b0, 1'b1, LAT_ALU);
            for (int j = 0; j < 4; j++) begin
                checkOutput("sat_br", 1'b1, (j < 3) ? 3'b011 : 3'b010, 1'b0);
                tick();
            end
            checkOutput("sat_br_issue", 1'b0, 3'b000, 1'b1);
            if (k == 2) check_val("sat_count_12", 32'(sb_if.stall_count), 32'd12);
            tick();
        end
        check_val("sat_count_max", 32'(sb_if.stall_count), 32'(CNT_MAX));

        idle();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
